// File: rtl/m2p_pkg.sv
// Shared constants for the M2P indication path: default message width and
// packed-field positions (method id in the top 16 bits, length in the bottom 16).
package m2p_pkg;
  localparam int WIDTH_DEFAULT = 144;
  localparam int METHOD_MSB    = 143;
  localparam int METHOD_LSB    = 128;
  localparam int LEN_MSB       = 15;
  localparam int LEN_LSB       = 0;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first valid entry
// after last, scanning last+1, last+2, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          any
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && valid[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/m2p_pipe_arbiter.sv
// Shares one marshalled-indication pipe between NREQ M2P marshallers: one
// holding slot per requester, round-robin drain into a single output register.
module m2p_pipe_arbiter
  import m2p_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_enq_ena,
  input  logic [NREQ*WIDTH-1:0] req_enq_v,
  output logic [NREQ-1:0]       req_enq_rdy,
  output logic                  pipe_enq_ena,
  output logic [WIDTH-1:0]      pipe_enq_v,
  input  logic                  pipe_enq_rdy,
  output logic [31:0]           msg_count,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  slot_valid;
  logic [WIDTH-1:0] slot_data [NREQ];
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    last_grant;
  logic [NREQ-1:0]  grant;
  logic             any;
  logic [IW-1:0]    grant_idx;
  logic             ld;
  logic             fire;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid (slot_valid),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

  assign fire = out_valid && pipe_enq_rdy;
  assign ld   = !out_valid || fire;

  // RDY comes only from slot state and reset, so it never depends on any ENA
  assign req_enq_rdy  = ~slot_valid & {NREQ{~RST}};
  assign pipe_enq_ena = fire;
  assign pipe_enq_v   = out_data;
  assign busy         = (|slot_valid) || out_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_valid <= '0;
      out_valid  <= 1'b0;
      last_grant <= IW'(NREQ - 1);
      msg_count  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_enq_ena[i] && !slot_valid[i]) slot_valid[i] <= 1'b1;
        else if (ld && grant[i])              slot_valid[i] <= 1'b0;
      end
      if (ld) begin
        out_valid <= any;
        if (any) last_grant <= grant_idx;
      end
      if (fire) msg_count <= msg_count + 32'd1;
    end
  end

  // Payload registers need no reset: their valid bits gate every use
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_enq_ena[i] && !slot_valid[i]) slot_data[i] <= req_enq_v[i*WIDTH +: WIDTH];
    end
    if (ld && any) out_data <= slot_data[grant_idx];
  end

endmodule

// File: tb/tb_m2p_pipe_arbiter.sv
// Directed bench for m2p_pipe_arbiter: stimulus pushes expected deliveries
// into a queue, a negedge monitor pops and compares on every pipe enq.
module tb_m2p_pipe_arbiter;
  import m2p_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = WIDTH_DEFAULT;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] ena;
  logic [NREQ*W-1:0] vbus;
  logic [NREQ-1:0] rdy;
  logic            pena;
  logic [W-1:0]    pdata;
  logic            pipe_rdy;
  logic [31:0]     cnt;
  logic            busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q [$];

  m2p_pipe_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .CLK          (clk),
    .RST          (rst),
    .req_enq_ena  (ena),
    .req_enq_v    (vbus),
    .req_enq_rdy  (rdy),
    .pipe_enq_ena (pena),
    .pipe_enq_v   (pdata),
    .pipe_enq_rdy (pipe_rdy),
    .msg_count    (cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] msg(input int r, input int tag);
    logic [W-1:0] m;
    m = '0;
    m[METHOD_MSB:METHOD_LSB] = 16'hA000 + 16'(r);
    m[127:16]                = {7{16'hC3A5}};
    m[LEN_MSB:LEN_LSB]       = 16'(tag);
    return m;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input int r, input int tag);
    exp_q.push_back(msg(r, tag));
  endtask

  task automatic enq(input logic [NREQ-1:0] mask, input int tag);
    ena = mask;
    for (int i = 0; i < NREQ; i++)
      vbus[i*W +: W] = mask[i] ? msg(i, tag) : '0;
    @(posedge clk); #1;
    ena = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (pena === 1'b1) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_delivery: got %h expected none", pdata);
        end else begin
          e = exp_q.pop_front();
          chk("delivery", pdata, e);
        end
      end
    end
  end

  initial begin
    clk = 0; rst = 1; ena = '0; vbus = '0; pipe_rdy = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_pipe_ena", pena, 0);
    chk("rst_count", cnt, 0);
    chk("rst_busy", busy, 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("post_rst_rdy", rdy, 4'hF);
    next_cycle();

    // two full bursts; last_grant ends at 3 each time so order is 0..3
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NREQ; i++) push(i, 1 + b);
      enq(4'hF, 1 + b);
      @(negedge clk);
      chk("min_latency", pena, 0);
      for (int k = 0; k < NREQ; k++) begin
        next_cycle();
        @(negedge clk);
        chk("burst_fire", pena, 1);
      end
      next_cycle();
    end
    @(negedge clk);
    chk("burst_count", cnt, 8);
    chk("burst_idle", busy, 0);
    next_cycle();

    push(2, 16'h00A5);
    enq(4'b0100, 16'h00A5);
    @(negedge clk);
    chk("single_rdy_low", rdy, 4'b1011);
    chk("single_no_fire_t1", pena, 0);
    next_cycle();
    @(negedge clk);
    chk("single_fire_t2", pena, 1);
    chk("single_rdy_back", rdy, 4'hF);
    next_cycle();
    @(negedge clk);
    chk("single_count", cnt, 9);
    next_cycle();

    // backpressure: last_grant=2, so req3 goes first and its slot is refilled
    pipe_rdy = 0;
    push(3, 4); push(0, 4); push(1, 4); push(2, 4); push(3, 5);
    enq(4'hF, 4);
    next_cycle();
    enq(4'b1000, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_no_fire", pena, 0);
      chk("bp_data_hold", pdata, msg(3, 4));
      chk("bp_rdy_low", rdy, 0);
      chk("bp_busy", busy, 1);
      next_cycle();
    end
    pipe_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_drain_fire", pena, 1);
      next_cycle();
    end
    @(negedge clk);
    chk("bp_count", cnt, 14);
    chk("bp_idle", busy, 0);
    next_cycle();

    // fairness: req0 refills immediately, req1 must still be served next
    push(0, 6); push(1, 6); push(0, 7);
    enq(4'b0011, 6);
    next_cycle();
    chk("fair_rdy0_back", rdy[0], 1);
    enq(4'b0001, 7);
    @(negedge clk);
    chk("fair_req1_granted", rdy[1], 1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("fair_count", cnt, 17);
    chk("fair_idle", busy, 0);
    next_cycle();

    // async reset with three slots and the output register full
    pipe_rdy = 0;
    enq(4'b0111, 9);
    next_cycle();
    enq(4'b0010, 10);
    @(negedge clk);
    chk("pre_rst_rdy", rdy, 4'b1000);
    chk("pre_rst_busy", busy, 1);
    #2;
    pipe_rdy = 1;
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pipe_ena", pena, 0);
    chk("arst_count", cnt, 0);
    chk("arst_rdy", rdy, 0);
    next_cycle();
    rst = 0;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("arst_no_output", cnt, 0);
    chk("arst_idle", busy, 0);
    chk("arst_rdy_back", rdy, 4'hF);

    chk("all_delivered", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
